// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, operand-source selects and bubble field values
// shared by the ID/EX stage and its forwarding muxes.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSB = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // A bubble is an all-zero entry: invalid, no side effects, ALU op ADD.
  localparam logic       NOP_VALID    = 1'b0;
  localparam logic       NOP_CTRL     = 1'b0;
  localparam logic [3:0] NOP_ALU_CODE = ALU_ADD;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects one ALU source from EX/MEM, MEM/WB or the registered read data.
// Muxing only exists with `EX_FORWARD_EN defined; otherwise the register data passes through.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);

`ifdef EX_FORWARD_EN
  logic exmem_hit_s;
  logic memwb_hit_s;

  assign exmem_hit_s = exmem_reg_write && (src_addr != {RA_W{1'b0}}) && (exmem_rd_addr == src_addr);
  assign memwb_hit_s = memwb_reg_write && (src_addr != {RA_W{1'b0}}) && (memwb_rd_addr == src_addr);

  // EX/MEM holds the younger result, so it wins over MEM/WB
  always_comb begin
    fwd_data = reg_data;
    if (exmem_hit_s) begin
      fwd_data = exmem_result;
    end else if (memwb_hit_s) begin
      fwd_data = memwb_result;
    end else begin
      fwd_data = reg_data;
    end
  end
`else
  logic unused_s;

  assign unused_s = ^{src_addr, exmem_reg_write, exmem_rd_addr, exmem_result,
                      memwb_reg_write, memwb_rd_addr, memwb_result};
  assign fwd_data = reg_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, ALU operand select, load-use stall and flush.
// `EX_FORWARD_EN enables forwarding; without it every RAW hazard on EX or EX/MEM stalls ID.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [3:0]      id_alu_code,
  input  logic            id_alusrc_a,
  input  logic            id_alusrc_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            stall_if_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_code,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic [XLEN-1:0] imm_r;
  logic [RA_W-1:0] rs1_addr_r;
  logic [RA_W-1:0] rs2_addr_r;
  logic [RA_W-1:0] rd_addr_r;
  logic [3:0]      alu_code_r;
  logic            alusrc_a_r;
  logic            alusrc_b_r;
  logic            reg_write_r;
  logic            mem_read_r;
  logic            mem_write_r;

  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic            ex_hit_s;
  logic            load_use_s;
  logic            raw_s;
  logic            stall_s;

  assign ex_hit_s   = (rd_addr_r != {RA_W{1'b0}}) &&
                      ((rd_addr_r == id_rs1_addr) || (rd_addr_r == id_rs2_addr));
  assign load_use_s = valid_r && mem_read_r && ex_hit_s;

`ifdef EX_FORWARD_EN
  assign raw_s = 1'b0;
`else
  // Without forwarding, any pending write in EX or EX/MEM to an ID source must drain first
  assign raw_s = (valid_r && reg_write_r && ex_hit_s) ||
                 (exmem_reg_write && (exmem_rd_addr != {RA_W{1'b0}}) &&
                  ((exmem_rd_addr == id_rs1_addr) || (exmem_rd_addr == id_rs2_addr)));
`endif

  assign stall_s     = id_valid && !flush && (load_use_s || raw_s);
  assign stall_if_id = stall_s;

  // ID/EX register: bubble on reset, flush or stall, otherwise capture the ID instruction
  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall_s) begin
      valid_r     <= NOP_VALID;
      pc_r        <= {XLEN{1'b0}};
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      rs1_addr_r  <= {RA_W{1'b0}};
      rs2_addr_r  <= {RA_W{1'b0}};
      rd_addr_r   <= {RA_W{1'b0}};
      alu_code_r  <= NOP_ALU_CODE;
      alusrc_a_r  <= SRC_A_RS1;
      alusrc_b_r  <= SRC_B_RS2;
      reg_write_r <= NOP_CTRL;
      mem_read_r  <= NOP_CTRL;
      mem_write_r <= NOP_CTRL;
    end else begin
      valid_r     <= id_valid;
      pc_r        <= id_pc;
      rs1_data_r  <= id_rs1_data;
      rs2_data_r  <= id_rs2_data;
      imm_r       <= id_imm;
      rs1_addr_r  <= id_rs1_addr;
      rs2_addr_r  <= id_rs2_addr;
      rd_addr_r   <= id_rd_addr;
      alu_code_r  <= id_alu_code;
      alusrc_a_r  <= id_alusrc_a;
      alusrc_b_r  <= id_alusrc_b;
      reg_write_r <= id_reg_write && id_valid;
      mem_read_r  <= id_mem_read && id_valid;
      mem_write_r <= id_mem_write && id_valid;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .src_addr        (rs1_addr_r),
    .reg_data        (rs1_data_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs1_s)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .src_addr        (rs2_addr_r),
    .reg_data        (rs2_data_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs2_s)
  );

  assign ex_valid      = valid_r;
  assign ex_pc         = pc_r;
  assign ex_a          = (alusrc_a_r == SRC_A_PC)  ? pc_r  : fwd_rs1_s;
  assign ex_b          = (alusrc_b_r == SRC_B_IMM) ? imm_r : fwd_rs2_s;
  assign ex_alu_code   = alu_code_r;
  assign ex_store_data = fwd_rs2_s;
  assign ex_rd_addr    = rd_addr_r;
  assign ex_reg_write  = reg_write_r;
  assign ex_mem_read   = mem_read_r;
  assign ex_mem_write  = mem_write_r;

endmodule
